// File: rtl/token_stream_fifo_if.sv
// token_stream_fifo_if: valid/ready token handshake bundle.
// master drives data/valid, slave drives ready.
interface token_stream_fifo_if #(
  parameter int WIDTH = 17
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/token_stream_fifo.sv
// token_stream_fifo: first-word-fall-through token FIFO that closes on a done token.
// Pop statistics are compiled in by defining TOKEN_STREAM_FIFO_STATS_EN.
module token_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  token_stream_fifo_if.slave  up,
  token_stream_fifo_if.master dn,
  output logic                done,
  output logic [15:0]         data_count,
  output logic [15:0]         stop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic open;
  logic push;
  logic pop;
  logic in_done;
  logic head_done;

  function automatic logic is_done(input logic [WIDTH-1:0] t);
    return t[WIDTH-1] & (t[9:8] == 2'b01);
  endfunction

  // in_ready depends only on registered state, never on out_ready
  assign open     = (state == IDLE) | (state == STREAM);
  assign up.ready = open & (count < CAP) & ~rst;

  assign dn.valid = (count != '0) & (state != DONE);
  assign dn.data  = mem[rd_ptr];

  assign push = clk_en & up.valid & up.ready;
  assign pop  = clk_en & dn.valid & dn.ready;

  assign in_done   = is_done(up.data);
  assign head_done = is_done(dn.data);

  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (push) begin
          state_nx = in_done ? DRAIN : STREAM;
        end
      end
      STREAM: begin
        if (push && in_done) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // done is the last token queued, so its pop empties the FIFO
        if (pop && head_done) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is cleared only through the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= up.data;
    end
  end

`ifdef TOKEN_STREAM_FIFO_STATS_EN
  logic head_data;
  logic head_stop;

  assign head_data = ~dn.data[WIDTH-1];
  assign head_stop = dn.data[WIDTH-1] & (dn.data[9:8] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_count <= '0;
      stop_count <= '0;
    end else if (pop) begin
      if (head_data && data_count != 16'hFFFF) begin
        data_count <= data_count + 16'd1;
      end
      if (head_stop && stop_count != 16'hFFFF) begin
        stop_count <= stop_count + 16'd1;
      end
    end
  end
`else
  assign data_count = '0;
  assign stop_count = '0;
`endif

endmodule

// File: doc/token_stream_fifo.md
TOKEN_STREAM_FIFO -- requirements
Module: token_stream_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have parameter WIDTH, default 17, token width; bit WIDTH-1 is the control flag.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port clk_en  input  1  when low, all state holds and no handshake completes.
REQ-007 SHALL have port in_data  input  WIDTH  token from upstream (read scanner coord_out or pos_out).
REQ-008 SHALL have port in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-009 SHALL have port out_data  output  WIDTH  token to the downstream consumer.
REQ-010 SHALL have port out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-011 SHALL have port done  output  1  sticky; done token has left out_data.
REQ-012 SHALL have ports data_count, stop_count  output  16 each  statistics (see Configuration).

Function
REQ-013 SHALL classify tokens: data when bit16=0; stop when bit16=1 and bits[9:8]=00; done when bit16=1 and bits[9:8]=01 (17'h10100).
REQ-014 SHALL transfer on a side when valid and ready are both high at the rising edge with clk_en=1.
REQ-015 SHALL be first-word-fall-through: a token accepted into an empty FIFO SHALL appear on out_data with out_valid=1 in the next cycle (latency 1).
REQ-016 SHALL drive in_ready = (state is IDLE or STREAM) and (occupancy < DEPTH), with no combinational path from out_ready.
REQ-017 SHALL allow simultaneous push and pop in one cycle, including when full (no push, since in_ready=0) and when empty (pop impossible; push only).
REQ-018 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-019 SHALL wrap read and write pointers modulo DEPTH; occupancy SHALL be tracked in log2(DEPTH)+1 bits.
REQ-020 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-021 SHALL move IDLE->STREAM on the first accepted non-done token.
REQ-022 SHALL move IDLE or STREAM->DRAIN on acceptance of a done token; in DRAIN in_ready=0.
REQ-023 SHALL move DRAIN->DONE on the cycle the done token pops; done=1 from the following cycle.
REQ-024 SHALL hold DONE (in_ready=0, out_valid=0, done=1) until rst.
REQ-025 SHALL pass stop and done tokens unchanged; the block never generates or drops tokens.

Reset
REQ-026 SHALL on rst=1 at a rising edge, regardless of clk_en, set state=IDLE, pointers and occupancy=0, done=0, counters=0, out_valid=0, in_ready=0 during the reset cycle.
REQ-027 SHALL discard queued tokens when rst asserts mid-stream; in_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL reset storage contents only via pointer clear; out_data is don't-care while out_valid=0.

Configuration
REQ-029 SHALL use macro TOKEN_STREAM_FIFO_STATS_EN to compile statistics in or out.
REQ-030 SHALL, with the macro defined, increment data_count per popped data token and stop_count per popped stop token, saturating at 16'hFFFF.
REQ-031 SHALL, without the macro, tie data_count and stop_count to 0 and instantiate no counter flops; all other behaviour identical.

Verification
REQ-032 SHALL pass: push 0x00003, 0x10000, 0x10100 with out_ready=1 -> same three tokens out in order, out_valid 1 cycle after each push, done=1 the cycle after 0x10100 pops, stop_count=1, data_count=1.
REQ-033 SHALL pass: DEPTH=4, out_ready=0, drive 6 data tokens -> exactly 4 accepted, in_ready=0 after 4th; raise out_ready -> remaining 2 accepted, 6 tokens out in order.
REQ-034 SHALL pass: full FIFO with in_valid=1, out_ready=1 for 10 cycles -> one pop per cycle, one push per cycle after the first pop, no loss or duplication.
REQ-035 SHALL pass: done token accepted with 2 data tokens queued, in_valid held high with 0x00005 -> in_ready=0 until rst; outputs the 2 data tokens then 0x10100; done=1; 0x00005 never accepted.
REQ-036 SHALL pass: rst pulsed with 3 tokens queued -> out_valid=0 next cycle, counters=0, done=0, then new stream 0x00007, 0x10100 passes normally.
REQ-037 SHALL pass: random valid/ready gaps on both sides across 1000 tokens -> output sequence equals input sequence, out_data stable while stalled.
